oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- Implements the OAM DMA engine behind register FF46. A CPU write to FF46 copies 160 bytes from {value, 8'h00} to OAM at FE00–FE9F.
- Sits between the CPU bus and the memory map's CPU port, and arbitrates that single port between the CPU and the DMA sequencer.
- While a transfer owns the bus, CPU accesses are blocked: reads return FF, writes are dropped. dma_active tells the PPU that OAM is unavailable.

Parameters:
- DMA_REG_ADDR, 16'hFF46, trigger/readback register address
- OAM_BASE, 16'hFE00, destination base
- DMA_LEN, 160, bytes per transfer
- START_DELAY, 1, cycles between trigger and first bus grab (≥1)

Ports:
- clock  in  1  system clock; the memory map's CPU port is synchronous to it, with 1-cycle read latency
- reset_n  in  1  asynchronous, active-low reset
- cpu_addr  in  16  CPU address
- cpu_wren  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data returned to CPU
- mem_addr  out  16  address to memory map
- mem_wren  out  1  write enable to memory map
- mem_wdata  out  8  write data to memory map
- mem_rdata  in  8  read data from memory map (valid 1 cycle after address)
- dma_active  out  1  transfer in progress (state != IDLE)

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, dma_reg=8'h00, index=0, rd_sel=0.
  - Outputs: mem_wren=0, mem_addr=cpu_addr passthrough, dma_active=0, cpu_rdata=mem_rdata.
  - Reset mid-transfer aborts immediately; OAM keeps any bytes already written.
- States: IDLE, START, READ, WRITE.
- Trigger: rising edge with cpu_wren=1 and cpu_addr=DMA_REG_ADDR, while the CPU owns the bus.
  - Sets dma_reg<=cpu_wdata, index<=0, delay counter<=START_DELAY-1, state<=START.
  - The trigger write is not forwarded (mem_wren=0 that cycle).
- IDLE: mem_addr=cpu_addr, mem_wren=cpu_wren except for the trigger address, mem_wdata=cpu_wdata.
- START:
  - The CPU still owns the bus.
  - Another trigger write restarts: dma_reg updated, delay reloaded.
  - Advances to READ when the delay counter reaches 0.
- READ:
  - mem_addr=src_base+index, mem_wren=0.
  - src_base={dma_reg,8'h00}; if dma_reg≥8'hE0 use {dma_reg-8'h20,8'h00} (echo mirror).
  - Next state: WRITE.
- WRITE:
  - mem_addr=OAM_BASE+index, mem_wdata=mem_rdata, mem_wren=1.
  - If index==DMA_LEN-1: go to IDLE and clear index. Else index+1 and go to READ.
- Timing:
  - Total bus ownership is 2·DMA_LEN = 320 cycles.
  - dma_active is high from the cycle after the trigger through the final WRITE inclusive, i.e. START_DELAY+320 cycles.
  - dma_active is low on the cycle after the last WRITE.
- CPU blocking (READ/WRITE):
  - CPU writes are dropped, except a write to DMA_REG_ADDR, which updates dma_reg and returns to START at the next edge. The in-flight byte is abandoned and index is reset to 0.
  - The HRAM exception is not implemented: the whole map is blocked.
- Read return path:
  - rd_sel is registered from the previous cycle. Values: 2 = blocked (CPU issued its access during READ/WRITE), 1 = cpu_addr==DMA_REG_ADDR, 0 = otherwise.
  - cpu_rdata = FF for 2, dma_reg for 1, mem_rdata for 0.
  - A FF46 read while blocked returns FF.
- Widths: index is 8 bits; address sums are 16-bit with no carry beyond bit 15.
- Simultaneous events: a trigger on the same edge as the final WRITE takes priority. The next state is START, not IDLE.

Decomposition:
- Package de10boy_pkg:
  - dma_state_t enum {IDLE, START, READ, WRITE}
  - constants DMA_REG_ADDR, OAM_BASE, DMA_LEN
- No sub-module: single always_ff plus output always_comb.

Test Plan:
- Trigger: write 8'hC1 to FF46; preload C100–C19F with i^8'h5A → FE00–FE9F hold i^8'h5A. dma_active is high for exactly 321 cycles and mem_wren pulses 160 times.
- Blocking: CPU read of C000 in cycle 10 of the transfer → cpu_rdata=FF the next cycle. CPU write of 8'h33 to C000 mid-transfer → C000 unchanged afterwards.
- Readback: write 8'h80 to FF46, wait for done, read FF46 → 8'h80. A read of FF46 during the transfer → FF.
- Restart: at byte 50 write 8'hD0 to FF46 → the transfer restarts from D000. Final OAM equals D000–D09F and dma_active stays high continuously.
- Echo: write 8'hE2 → the source is C200–C29F.
- Reset: assert reset_n low at byte 80 → dma_active=0 and mem_wren=0 asynchronously. FE00–FE4F are written, FE50–FE9F untouched; dma_reg reads 8'h00.

Source files
------------

// File: rtl/de10boy_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Package     : de10boy_pkg                                                |
// | Description : Shared types and constants for the OAM DMA engine.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package de10boy_pkg;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  // Source of the data returned to the CPU one cycle after its access.
  typedef enum logic [1:0] {
    RD_MEM     = 2'd0,
    RD_REG     = 2'd1,
    RD_BLOCKED = 2'd2
  } rd_sel_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          DMA_LEN      = 160;

endpackage

`default_nettype wire

// File: rtl/oam_dma_controller.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : oam_dma_controller                                         |
// | Description : FF46 OAM DMA engine. A CPU write to FF46 copies 160 bytes  |
// |               from {value,8'h00} into OAM (FE00-FE9F), arbitrating the   |
// |               single memory-map port between the CPU and the sequencer.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports:
//   clock      in   system clock (memory map read latency is 1 cycle)
//   reset_n    in   asynchronous active-low reset
//   cpu_addr   in   [15:0] CPU address
//   cpu_wren   in   CPU write strobe
//   cpu_wdata  in   [7:0]  CPU write data
//   cpu_rdata  out  [7:0]  read data returned to the CPU
//   mem_addr   out  [15:0] address to the memory map
//   mem_wren   out  write enable to the memory map
//   mem_wdata  out  [7:0]  write data to the memory map
//   mem_rdata  in   [7:0]  read data from the memory map
//   dma_active out  transfer in progress (OAM unavailable to the PPU)
//------------------------------------------------------------------------------
`default_nettype none

module oam_dma_controller
  import de10boy_pkg::*;
#(
  parameter int unsigned START_DELAY = 1   // cycles from trigger to first bus grab, >= 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wren,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_wren,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  // The delay counter only ever holds START_DELAY-1 down to 0.
  localparam int          DW         = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DW-1:0] DELAY_INIT = DW'(START_DELAY - 1);
  localparam logic [7:0]  LAST_INDEX = 8'(DMA_LEN - 1);

  dma_state_t    state_q,   state_d;
  logic [7:0]    dma_reg_q, dma_reg_d;
  logic [7:0]    index_q,   index_d;
  logic [DW-1:0] delay_q,   delay_d;
  rd_sel_t       rd_sel_q,  rd_sel_d;

  logic          w_is_reg;
  logic          w_trigger;
  logic          w_blocked;
  logic [7:0]    w_src_hi;

  assign w_is_reg  = (cpu_addr == DMA_REG_ADDR);
  // A write to FF46 is honoured in every state, including while the bus is held.
  assign w_trigger = cpu_wren && w_is_reg;
  assign w_blocked = (state_q == READ) || (state_q == WRITE);

  // Sources in E000-FFFF fold down onto the work-RAM echo at C000-DFFF.
  assign w_src_hi  = (dma_reg_q >= 8'hE0) ? (dma_reg_q - 8'h20) : dma_reg_q;

  //----------------------------------------------------------------------------
  // Next-state logic
  //----------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    dma_reg_d = dma_reg_q;
    index_d   = index_q;
    delay_d   = delay_q;

    if (w_blocked)     rd_sel_d = RD_BLOCKED;
    else if (w_is_reg) rd_sel_d = RD_REG;
    else               rd_sel_d = RD_MEM;

    if (w_trigger) begin
      // Fresh start or restart: any in-flight byte is abandoned.
      state_d   = START;
      dma_reg_d = cpu_wdata;
      index_d   = 8'h00;
      delay_d   = DELAY_INIT;
    end else begin
      case (state_q)
        START: begin
          if (delay_q == '0) state_d = READ;
          else               delay_d = delay_q - DW'(1);
        end
        READ: begin
          state_d = WRITE;
        end
        WRITE: begin
          if (index_q == LAST_INDEX) begin
            state_d = IDLE;
            index_d = 8'h00;
          end else begin
            state_d = READ;
            index_d = index_q + 8'h01;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  //----------------------------------------------------------------------------
  // State registers
  //----------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dma_reg_q <= 8'h00;
      index_q   <= 8'h00;
      delay_q   <= '0;
      rd_sel_q  <= RD_MEM;
    end else begin
      state_q   <= state_d;
      dma_reg_q <= dma_reg_d;
      index_q   <= index_d;
      delay_q   <= delay_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  //----------------------------------------------------------------------------
  // Bus mux and read return
  //----------------------------------------------------------------------------
  always_comb begin
    // CPU owns the port in IDLE and START; the trigger write itself is swallowed.
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wren  = cpu_wren && !w_is_reg;

    case (state_q)
      READ: begin
        // Low source byte is always 00, so {hi,index} equals base+index.
        mem_addr = {w_src_hi, index_q};
        mem_wren = 1'b0;
      end
      WRITE: begin
        // The byte fetched in READ is on mem_rdata this cycle.
        mem_addr  = OAM_BASE + {8'h00, index_q};
        mem_wdata = mem_rdata;
        mem_wren  = 1'b1;
      end
      default: begin
        mem_addr = cpu_addr;
      end
    endcase

    case (rd_sel_q)
      RD_BLOCKED: cpu_rdata = 8'hFF;
      RD_REG:     cpu_rdata = dma_reg_q;
      default:    cpu_rdata = mem_rdata;
    endcase
  end

  assign dma_active = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_oam_dma_controller                                      |
// | Description : Directed self-checking bench for oam_dma_controller with a |
// |               64 KiB synchronous memory-map model (1-cycle read).        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_oam_dma_controller;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr  = 16'h0000;
  logic        cpu_wren  = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_wren;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        dma_active;

  logic [7:0]  mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  oam_dma_controller #(.START_DELAY(1)) u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_addr   (cpu_addr),
    .cpu_wren   (cpu_wren),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wren   (mem_wren),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  always #5 clock = ~clock;

  // Memory map: read data registered (old contents on a same-cycle write).
  always @(posedge clock) begin
    mem_rdata <= mem[mem_addr];
    if (mem_wren) mem[mem_addr] = mem_wdata;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] pat(input int i, input logic [7:0] key);
    return 8'(i) ^ key;
  endfunction

  task automatic preload(input logic [15:0] base, input logic [7:0] key);
    for (int i = 0; i < 160; i++) mem[base + 16'(i)] = pat(i, key);
  endtask

  task automatic fill_oam(input logic [7:0] v);
    for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = v;
  endtask

  task automatic check_oam(input string tag, input logic [7:0] key);
    for (int i = 0; i < 160; i++) check(tag, {8'h00, mem[16'hFE00 + 16'(i)]}, {8'h00, pat(i, key)});
  endtask

  // Called at a negedge; returns at the next negedge with the trigger taken.
  task automatic do_trigger(input logic [7:0] v);
    cpu_addr  = 16'hFF46;
    cpu_wdata = v;
    cpu_wren  = 1'b1;
    @(negedge clock);
    cpu_wren  = 1'b0;
    cpu_addr  = 16'h0000;
  endtask

  // Counts active cycles and write pulses until dma_active drops (bounded).
  task automatic measure(output int act, output int wr);
    act = 0;
    wr  = 0;
    for (int k = 0; k < 1000 && dma_active; k++) begin
      act++;
      if (mem_wren) wr++;
      @(negedge clock);
    end
  endtask

  // Waits until the n-th OAM write pulse is on the bus (bounded).
  task automatic wait_writes(input int n, output int seen);
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      if (mem_wren) seen++;
      if (seen == n) break;
      @(negedge clock);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act, wr, seen;

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    preload(16'hC100, 8'h5A);
    preload(16'h8000, 8'h3C);
    preload(16'hD000, 8'hA5);
    preload(16'hC200, 8'hC3);
    preload(16'hE200, 8'h11);
    preload(16'h9000, 8'h77);
    mem[16'hC000] = 8'h77;
    fill_oam(8'hEE);

    // Reset state
    repeat (3) @(negedge clock);
    cpu_addr = 16'h1234;
    #1;
    check("rst_active", {15'd0, dma_active}, 16'd0);
    check("rst_wren",   {15'd0, mem_wren},   16'd0);
    check("rst_addr",   mem_addr,            16'h1234);
    @(negedge clock);
    reset_n = 1'b1;

    // FF46 reads back 00 after reset
    cpu_addr = 16'hFF46;
    @(negedge clock);
    check("rst_dmareg", {8'h00, cpu_rdata}, 16'h0000);

    // Idle pass-through write and read
    cpu_addr = 16'hC010; cpu_wdata = 8'hAB; cpu_wren = 1'b1;
    #1;
    check("idle_wren", {15'd0, mem_wren}, 16'd1);
    @(negedge clock);
    cpu_wren = 1'b0;
    check("idle_wr", {8'h00, mem[16'hC010]}, 16'h00AB);
    @(negedge clock);
    check("idle_rd", {8'h00, cpu_rdata}, 16'h00AB);

    // Basic transfer from C100; trigger write is not forwarded
    cpu_addr = 16'hFF46; cpu_wdata = 8'hC1; cpu_wren = 1'b1;
    #1;
    check("trig_nofwd", {15'd0, mem_wren}, 16'd0);
    @(negedge clock);
    cpu_wren = 1'b0; cpu_addr = 16'h0000;
    measure(act, wr);
    check("t1_active", 16'(act), 16'd321);
    check("t1_writes", 16'(wr),  16'd160);
    check_oam("t1_oam", 8'h5A);

    // Blocking of CPU reads and writes mid-transfer
    fill_oam(8'hEE);
    do_trigger(8'hC1);
    repeat (9) @(negedge clock);
    cpu_addr = 16'hC000;
    @(negedge clock);
    check("blk_rd", {8'h00, cpu_rdata}, 16'h00FF);
    cpu_addr = 16'hFF46;
    @(negedge clock);
    check("blk_reg", {8'h00, cpu_rdata}, 16'h00FF);
    cpu_addr = 16'hC000; cpu_wdata = 8'h33; cpu_wren = 1'b1;
    @(negedge clock);
    cpu_wren = 1'b0; cpu_addr = 16'h0000;
    measure(act, wr);
    check("blk_wr_drop", {8'h00, mem[16'hC000]}, 16'h0077);
    check_oam("blk_oam", 8'h5A);

    // Register readback after a transfer from 8000
    do_trigger(8'h80);
    measure(act, wr);
    check("rb_active", 16'(act), 16'd321);
    check("rb_writes", 16'(wr),  16'd160);
    check_oam("rb_oam", 8'h3C);
    cpu_addr = 16'hFF46;
    @(negedge clock);
    check("rb_reg", {8'h00, cpu_rdata}, 16'h0080);
    cpu_addr = 16'h0000;
    @(negedge clock);

    // Restart at byte 50 with a new source
    fill_oam(8'hEE);
    do_trigger(8'hC1);
    wait_writes(50, seen);
    check("rs_seen", 16'(seen), 16'd50);
    check("rs_active_pre", {15'd0, dma_active}, 16'd1);
    do_trigger(8'hD0);
    measure(act, wr);
    check("rs_active", 16'(act), 16'd321);
    check("rs_writes", 16'(wr),  16'd160);
    check_oam("rs_oam", 8'hA5);

    // Echo mirror: E2 sources from C200
    fill_oam(8'hEE);
    do_trigger(8'hE2);
    measure(act, wr);
    check("echo_active", 16'(act), 16'd321);
    check_oam("echo_oam", 8'hC3);

    // Asynchronous reset during the write of byte 80
    fill_oam(8'hEE);
    do_trigger(8'h90);
    wait_writes(80, seen);
    check("rst80_seen", 16'(seen), 16'd80);
    @(posedge clock);
    @(posedge clock);
    #2;
    check("rst80_pre_wren", {15'd0, mem_wren}, 16'd1);
    reset_n = 1'b0;
    #1;
    check("rst80_active", {15'd0, dma_active}, 16'd0);
    check("rst80_wren",   {15'd0, mem_wren},   16'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 80; i++)
      check("rst80_done", {8'h00, mem[16'hFE00 + 16'(i)]}, {8'h00, pat(i, 8'h77)});
    for (int i = 80; i < 160; i++)
      check("rst80_untouched", {8'h00, mem[16'hFE00 + 16'(i)]}, 16'h00EE);
    cpu_addr = 16'hFF46;
    @(negedge clock);
    check("rst80_dmareg", {8'h00, cpu_rdata}, 16'h0000);
    cpu_addr = 16'h0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
